// File: rtl/life_gen_sequencer_pkg.sv
// Shared types and default dimensions for the Game-of-Life generation sequencer.
package life_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    COMMIT,
    DELAY
  } state_t;

  localparam int DEF_ROWS     = 8;
  localparam int DEF_COLS     = 8;
  localparam int DEF_GEN_W    = 11;
  localparam int DEF_PERIOD_W = 16;

endpackage

// File: rtl/life_gen_sequencer_if.sv
// Control, compute-unit and board-bank signals of the generation sequencer.
interface life_gen_sequencer_if #(
  parameter int ADDR_W   = 6,
  parameter int GEN_W    = 11,
  parameter int PERIOD_W = 16
);

  logic                start;
  logic                run;
  logic                halt;
  logic [PERIOD_W-1:0] period;
  // calc_req pulses once per cell; calc_valid is honoured only while the
  // sequencer waits on that cell, and cell_addr is held stable until it arrives.
  logic                calc_valid;
  logic [ADDR_W-1:0]   cell_addr;
  logic                calc_req;
  logic                next_we;
  logic                commit_we;
  logic [GEN_W-1:0]    generation;
  logic                busy;
  logic                done;
  life_pkg::state_t    dbg_state;

  modport master (
    input  start, run, halt, period, calc_valid,
    output cell_addr, calc_req, next_we, commit_we, generation, busy, done, dbg_state
  );

  modport slave (
    output start, run, halt, period, calc_valid,
    input  cell_addr, calc_req, next_we, commit_we, generation, busy, done, dbg_state
  );

endinterface

// File: rtl/dff.sv
// Parameterized register with write enable and asynchronous active-low clear.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/life_gen_sequencer_delay.sv
// Loadable down-counter timing the gap between free-running generations.
module gen_delay_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     count <= '0;
    else if (load)                  count <= load_val;
    else if (dec && count != '0)    count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/life_gen_sequencer.sv
// Walks every cell through the compute unit, then commits the shadow board
// and counts the generation; supports single-step and delayed free-run.
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int ADDR_W   = $clog2(ROWS*COLS),
  parameter int GEN_W    = DEF_GEN_W,
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                  clk,
  input  logic                  reset,
  life_gen_sequencer_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS*COLS-1);

  state_t              state;
  logic [ADDR_W-1:0]   cell_addr;
  logic                calc_req;
  logic                next_we;
  logic                commit_we;
  logic                busy;
  logic                free_run;
  logic                delay_zero;
  logic [PERIOD_W-1:0] delay_load_val;
  logic [GEN_W-1:0]    generation;
  logic [GEN_W-1:0]    gen_next;

  assign free_run       = bus.run & ~bus.halt;
  assign delay_load_val = bus.period - PERIOD_W'(1);
  assign gen_next       = generation + GEN_W'(1);

  // run/halt are only consulted at IDLE, COMMIT and DELAY, so a started
  // generation always runs through to its commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cell_addr <= '0;
      calc_req  <= 1'b0;
      next_we   <= 1'b0;
      commit_we <= 1'b0;
      busy      <= 1'b0;
    end else begin
      calc_req  <= 1'b0;
      next_we   <= 1'b0;
      commit_we <= 1'b0;
      case (state)
        IDLE: begin
          if ((bus.start | bus.run) & ~bus.halt) begin
            state     <= ISSUE;
            cell_addr <= '0;
            calc_req  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.calc_valid) begin
            state   <= WRITE;
            next_we <= 1'b1;
          end
        end
        WRITE: begin
          if (cell_addr == LAST_ADDR) begin
            state     <= COMMIT;
            cell_addr <= '0;
            commit_we <= 1'b1;
          end else begin
            state     <= ISSUE;
            cell_addr <= cell_addr + ADDR_W'(1);
            calc_req  <= 1'b1;
          end
        end
        COMMIT: begin
          if (free_run && bus.period == '0) begin
            state    <= ISSUE;
            calc_req <= 1'b1;
          end else if (free_run) begin
            state <= DELAY;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DELAY: begin
          if (!free_run) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (delay_zero) begin
            state    <= ISSUE;
            calc_req <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Loaded every COMMIT; only the DELAY path ever looks at it.
  gen_delay_counter #(.W(PERIOD_W)) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (state == COMMIT),
    .load_val (delay_load_val),
    .dec      (state == DELAY),
    .zero     (delay_zero)
  );

  dff #(.W(GEN_W)) u_generation (
    .clk   (clk),
    .reset (reset),
    .we    (commit_we),
    .d     (gen_next),
    .q     (generation)
  );

  assign bus.cell_addr  = cell_addr;
  assign bus.calc_req   = calc_req;
  assign bus.next_we    = next_we;
  assign bus.commit_we  = commit_we;
  assign bus.done       = commit_we;
  assign bus.busy       = busy;
  assign bus.generation = generation;
  assign bus.dbg_state  = state;

endmodule
